pt_stream: RTL
==============

PT_STREAM -- requirements
Module: pt_stream

Interface
REQ-001 clk  input  1  single clock; all state updates on the rising edge.
REQ-002 rst  input  1  asynchronous, active-high reset.
REQ-003 en  input  1  start request; accepted only on an edge where rdy=1.
REQ-004 rdy  output  1  high when the block can accept en (IDLE or DONE).
REQ-005 key_in  input  24  cracked ARC4 key from the upstream cracker.
REQ-006 key_valid_in  input  1  high when key_in holds a valid key.
REQ-007 pt_addr  output  8  plaintext memory read address.
REQ-008 pt_rddata  input  8  plaintext memory data; valid one cycle after pt_addr is sampled.
REQ-009 out_data  output  8  streamed plaintext byte.
REQ-010 out_valid  output  1  out_data valid; held until accepted.
REQ-011 out_ready  input  1  downstream consumer accepts out_data when out_valid=1 and out_ready=1.
REQ-012 key_out  output  24  key latched at en acceptance.
REQ-013 done  output  1  high when the stream completes; held until the next en is accepted.
REQ-014 err  output  1  high when a run aborts (invalid key or non-printable byte).

Function
REQ-015 Memory format SHALL be length-prefixed: pt[0]=length L (0..255), pt[1..L]=characters.
REQ-016 States SHALL be IDLE, RDLEN, WAITLEN, RDCHAR, WAITCHAR, EMIT, DONE.
REQ-017 On en=1 with rdy=1, the block SHALL latch key_in into key_out, clear done and err, drive pt_addr=0, and go to RDLEN.
REQ-018 If key_valid_in=0 at acceptance, the block SHALL go directly to DONE with err=1, perform no memory reads, and emit no bytes.
REQ-019 RDLEN->WAITLEN; WAITLEN SHALL latch L from pt_rddata, then go to DONE if L=0, otherwise go to RDCHAR with pt_addr=1.
REQ-020 RDCHAR->WAITCHAR; WAITCHAR SHALL load pt_rddata into out_data and go to EMIT with out_valid=1.
REQ-021 out_valid SHALL first rise 4 edges after the accepting edge.
REQ-022 With out_ready held high, bytes SHALL be emitted every 3 cycles.
REQ-023 While in EMIT with out_ready=0, out_data and out_valid SHALL stay stable indefinitely.
REQ-024 On handshake: if index=L, go to DONE; otherwise increment the index and pt_addr and go to RDCHAR.
REQ-025 The index SHALL be 8-bit and SHALL never wrap, since L=255 ends at address 255.
REQ-026 en while busy (not IDLE/DONE) SHALL be ignored.
REQ-027 en in DONE SHALL restart a new run.
REQ-028 On entering DONE, the block SHALL set done=1, out_valid=0, rdy=1.

Reset
REQ-029 rst=1 SHALL immediately force IDLE, regardless of state, including mid-stream.
REQ-030 On reset, the block SHALL drive rdy=1, done=0, err=0, out_valid=0, out_data=0, pt_addr=0, key_out=0.
REQ-031 After rst deasserts, the block SHALL require a fresh en; no partial stream resumes.

Configuration
REQ-032 With ASCII_CHECK_EN defined, a byte outside 0x20..0x7E read in WAITCHAR SHALL NOT be emitted; the block SHALL go to DONE with err=1.
REQ-033 Without ASCII_CHECK_EN, all bytes SHALL be emitted unchanged, and err SHALL be set only by REQ-018.

Verification
REQ-034 Reset: after reset -> rdy=1, done=0, err=0, out_valid=0, key_out=0.
REQ-035 Normal stream: pt = {03,'H','i','!'}, key_valid_in=1, key_in=0x1E4600, out_ready=1, en pulse -> key_out=0x1E4600; bytes 0x48,0x69,0x21 emitted; first out_valid 4 edges after acceptance; 3-cycle spacing; then done=1, err=0.
REQ-036 Backpressure: same data, out_ready=0 for 10 cycles on the second byte -> 0x69 held stable with out_valid=1; stream completes correctly.
REQ-037 Boundaries: L=0 -> done with no out_valid. L=255 with ASCII_CHECK_EN undefined -> 255 bytes emitted, last pt_addr=0xFF.
REQ-038 Errors: key_valid_in=0 at en -> done=1, err=1, no reads. With ASCII_CHECK_EN, pt = {02,'A',0x07} -> 'A' emitted, then err=1, done=1, 0x07 never emitted.
REQ-039 Mid-stream reset: rst pulse during EMIT -> out_valid drops asynchronously, rdy=1; a subsequent en replays from address 0.

Source files
------------

// File: rtl/pt_stream.sv
// Plaintext streamer: reads a length-prefixed string from memory and emits it byte by byte.
// Latency: first out_valid 4 edges after en acceptance, then one byte per 3 cycles.
// Backpressure: out_valid/out_data hold while out_ready=0. Optional ASCII_CHECK_EN aborts on non-printable bytes.
module pt_stream (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    output logic        rdy,
    input  logic [23:0] key_in,
    input  logic        key_valid_in,
    output logic [7:0]  pt_addr,
    input  logic [7:0]  pt_rddata,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [23:0] key_out,
    output logic        done,
    output logic        err
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RDLEN,
        ST_WAITLEN,
        ST_RDCHAR,
        ST_WAITCHAR,
        ST_EMIT,
        ST_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  pt_addr_q, pt_addr_d;
    logic [7:0]  idx_q, idx_d;
    logic [7:0]  len_q, len_d;
    logic [7:0]  out_data_q, out_data_d;
    logic        out_valid_q, out_valid_d;
    logic [23:0] key_out_q, key_out_d;
    logic        done_q, done_d;
    logic        err_q, err_d;

    always_comb begin
        state_d     = state_q;
        pt_addr_d   = pt_addr_q;
        idx_d       = idx_q;
        len_d       = len_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        key_out_d   = key_out_q;
        done_d      = done_q;
        err_d       = err_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (en) begin
                    key_out_d   = key_in;
                    done_d      = 1'b0;
                    err_d       = 1'b0;
                    pt_addr_d   = 8'h00;
                    out_valid_d = 1'b0;
                    if (key_valid_in) begin
                        state_d = ST_RDLEN;
                    end else begin
                        // No usable key: abort without touching memory.
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                    end
                end
            end
            ST_RDLEN: begin
                state_d = ST_WAITLEN;
            end
            ST_WAITLEN: begin
                len_d = pt_rddata;
                if (pt_rddata == 8'h00) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end else begin
                    state_d   = ST_RDCHAR;
                    pt_addr_d = 8'h01;
                    idx_d     = 8'h01;
                end
            end
            ST_RDCHAR: begin
                state_d = ST_WAITCHAR;
            end
            ST_WAITCHAR: begin
`ifdef ASCII_CHECK_EN
                if ((pt_rddata < 8'h20) || (pt_rddata > 8'h7E)) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                end else begin
                    out_data_d  = pt_rddata;
                    out_valid_d = 1'b1;
                    state_d     = ST_EMIT;
                end
`else
                out_data_d  = pt_rddata;
                out_valid_d = 1'b1;
                state_d     = ST_EMIT;
`endif
            end
            ST_EMIT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    // Compare before incrementing so L=255 finishes at address 255 without wrapping.
                    if (idx_q == len_q) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else begin
                        idx_d     = idx_q + 8'h01;
                        pt_addr_d = pt_addr_q + 8'h01;
                        state_d   = ST_RDCHAR;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            pt_addr_q   <= 8'h00;
            idx_q       <= 8'h00;
            len_q       <= 8'h00;
            out_data_q  <= 8'h00;
            out_valid_q <= 1'b0;
            key_out_q   <= 24'h000000;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            pt_addr_q   <= pt_addr_d;
            idx_q       <= idx_d;
            len_q       <= len_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            key_out_q   <= key_out_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign rdy       = (state_q == ST_IDLE) || (state_q == ST_DONE);
    assign pt_addr   = pt_addr_q;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign key_out   = key_out_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule
